// File: rtl/z16_fetch_pkg.sv
// Shared types and derived-constant helpers for the Z16 instruction fetch unit.
package z16_fetch_pkg;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_INSTR_W = 16;
  localparam int unsigned DEF_DEPTH   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  // Bytes per instruction, i.e. the PC increment.
  function automatic int unsigned pc_step(input int unsigned instr_w);
    return instr_w / 8;
  endfunction

  // Number of always-zero low PC bits.
  function automatic int unsigned align_bits(input int unsigned instr_w);
    return $clog2(instr_w / 8);
  endfunction

  // Queue pointer width.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/z16_fetch_queue.sv
// Prefetch queue: circular buffer of {pc, instr} with flush, registered head.
module z16_fetch_queue
  import z16_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned INSTR_W = DEF_INSTR_W,
  parameter int unsigned DEPTH   = DEF_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [ADDR_W-1:0]        i_push_pc,
  input  logic [INSTR_W-1:0]       i_push_instr,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [ADDR_W-1:0]        o_head_pc,
  output logic [INSTR_W-1:0]       o_head_instr,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  r_pc_mem    [DEPTH];
  logic [INSTR_W-1:0] r_instr_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_pop;
  logic               w_do_push;

  // Qualify push/pop: pop of an empty queue is ignored, push only with space.
  always_comb begin
    w_do_pop  = i_pop && (r_count != '0);
    w_do_push = i_push && ((r_count != DEPTH_C) || w_do_pop);
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

  // Entry storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (w_do_push && !i_flush) begin
      r_pc_mem[r_wr_ptr]    <= i_push_pc;
      r_instr_mem[r_wr_ptr] <= i_push_instr;
    end
  end

  assign o_valid      = (r_count != '0);
  assign o_head_pc    = r_pc_mem[r_rd_ptr];
  assign o_head_instr = r_instr_mem[r_rd_ptr];
  assign o_count      = r_count;

endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 fetch front end: handshaked imem port, prefetch queue, redirect/squash.
module z16_fetch_unit
  import z16_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter int unsigned       DEPTH    = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  output logic                   o_imem_req,
  output logic [ADDR_W-1:0]      o_imem_addr,
  input  logic                   i_imem_gnt,
  input  logic                   i_imem_rvalid,
  input  logic [INSTR_W-1:0]     i_imem_rdata,
  input  logic                   i_redirect,
  input  logic [ADDR_W-1:0]      i_redirect_pc,
  output logic                   o_instr_valid,
  output logic [INSTR_W-1:0]     o_instr,
  output logic [ADDR_W-1:0]      o_instr_pc,
  input  logic                   i_instr_ready,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PC_STEP    = pc_step(INSTR_W);
  localparam int unsigned ALIGN_BITS = align_bits(INSTR_W);
  localparam int unsigned PTR_W      = ptr_w(DEPTH);
  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1));

  fetch_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_fetch_pc, w_fetch_pc_nxt;
  logic [ADDR_W-1:0]  r_req_pc, w_req_pc_nxt;
  logic               r_squash, w_squash_nxt;
  logic               r_imem_req;
  logic               r_armed;
  logic               w_push;
  logic               w_pop;
  logic               w_head_valid;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_cnt_after;

  // Next-state, PC, squash and queue control.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_squash_nxt   = r_squash;
    w_push         = 1'b0;
    w_pop          = i_instr_ready && w_head_valid && !i_redirect;
    w_cnt_after    = w_count;

    case (r_state)
      IDLE: begin
        if (!i_redirect && (w_count < DEPTH_C)) w_state_nxt = REQ;
      end
      REQ: begin
        if (i_imem_gnt) begin
          // A grant coincident with a redirect is still outstanding: squash it.
          w_req_pc_nxt   = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + ADDR_W'(PC_STEP);
          w_state_nxt    = WAIT;
          if (i_redirect) w_squash_nxt = 1'b1;
        end else if (i_redirect) begin
          w_state_nxt = IDLE;
        end
      end
      WAIT: begin
        if (i_imem_rvalid) begin
          w_squash_nxt = 1'b0;
          if (i_redirect) begin
            w_state_nxt = REQ;
          end else begin
            w_push      = !r_squash;
            w_cnt_after = w_count + CNT_W'(!r_squash) - CNT_W'(w_pop);
            w_state_nxt = (w_cnt_after < DEPTH_C) ? REQ : IDLE;
          end
        end else if (i_redirect) begin
          w_squash_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    if (i_redirect) w_fetch_pc_nxt = i_redirect_pc & ALIGN_MASK;
  end

  // State, PC and request registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_squash   <= 1'b0;
      r_imem_req <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_squash   <= w_squash_nxt;
      r_imem_req <= (w_state_nxt == REQ);
    end
  end

  // Responses before the first grant after reset may be stale; ignore them.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       r_armed <= 1'b0;
    else if (r_imem_req && i_imem_gnt)  r_armed <= 1'b1;
  end

  z16_fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH)
  ) u_queue (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_flush      (i_redirect),
    .i_push       (w_push),
    .i_push_pc    (r_req_pc),
    .i_push_instr (i_imem_rdata),
    .i_pop        (w_pop),
    .o_valid      (w_head_valid),
    .o_head_pc    (o_instr_pc),
    .o_head_instr (o_instr),
    .o_count      (w_count)
  );

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_fetch_pc;
  assign o_instr_valid = w_head_valid;
  assign o_count       = w_count;

  // Address must hold while a request waits for grant.
  a_addr_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_imem_req && !i_imem_gnt && !i_redirect) |=> $stable(r_fetch_pc));

  // Read data only arrives for the outstanding request.
  a_rvalid_in_wait: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_armed && i_imem_rvalid) |-> (r_state == WAIT));

endmodule

// File: tb/tb_z16_fetch_unit.sv
// Directed scoreboard bench for z16_fetch_unit.
module tb_z16_fetch_unit;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  logic        i_clk;
  logic        i_rst_n;
  logic        o_imem_req;
  logic [15:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [15:0] i_imem_rdata;
  logic        i_redirect;
  logic [15:0] i_redirect_pc;
  logic        o_instr_valid;
  logic [15:0] o_instr;
  logic [15:0] o_instr_pc;
  logic        i_instr_ready;
  logic [2:0]  o_count;

  logic        o2_req;
  logic [15:0] o2_addr;
  logic        i2_rvalid;
  logic [15:0] i2_rdata;
  logic        o2_valid;
  logic [15:0] o2_instr;
  logic [15:0] o2_pc;
  logic [2:0]  o2_count;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  logic        gnt_en, auto_rsp, ready_v;
  bit          pend, pend_stale, pend2;
  logic [15:0] pend_addr, pend2_addr;
  exp_t        exp_q[$];
  logic [15:0] req_log[$];
  int          grant_cyc[$];
  logic [15:0] dlv_log[$];
  logic [15:0] log2[$];
  int          c0;

  z16_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'h0000)) u_dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr), .i_imem_gnt(i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_instr_valid(o_instr_valid), .o_instr(o_instr), .o_instr_pc(o_instr_pc),
    .i_instr_ready(i_instr_ready), .o_count(o_count)
  );

  z16_fetch_unit #(.ADDR_W(16), .INSTR_W(16), .DEPTH(4), .RESET_PC(16'hFFFC)) u_dut_hi (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_imem_req(o2_req), .o_imem_addr(o2_addr), .i_imem_gnt(1'b1),
    .i_imem_rvalid(i2_rvalid), .i_imem_rdata(i2_rdata),
    .i_redirect(1'b0), .i_redirect_pc(16'h0000),
    .o_instr_valid(o2_valid), .o_instr(o2_instr), .o_instr_pc(o2_pc),
    .i_instr_ready(1'b1), .o_count(o2_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs at the falling edge, model memory and scoreboard.
  task automatic cyc(input bit redir = 1'b0, input logic [15:0] rpc = 16'h0000);
    exp_t e;
    @(negedge i_clk);
    cyc_n++;
    i_redirect    = redir;
    i_redirect_pc = rpc;
    i_instr_ready = ready_v;
    if (o_instr_valid && ready_v && !redir) begin
      dlv_log.push_back(o_instr_pc);
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("instr_pc", 32'(o_instr_pc), 32'(e.pc));
        chk("instr", 32'(o_instr), 32'(e.instr));
      end
    end
    if (pend && auto_rsp) begin
      i_imem_rvalid = 1'b1;
      i_imem_rdata  = pend_addr ^ 16'hA5A5;
      if (!pend_stale && !redir) begin
        e.pc = pend_addr;
        e.instr = pend_addr ^ 16'hA5A5;
        exp_q.push_back(e);
      end
      pend = 1'b0;
    end else begin
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 16'h0000;
      if (redir && pend) pend_stale = 1'b1;
    end
    i_imem_gnt = gnt_en;
    if (o_imem_req && gnt_en) begin
      pend       = 1'b1;
      pend_addr  = o_imem_addr;
      pend_stale = redir;
      req_log.push_back(o_imem_addr);
      grant_cyc.push_back(cyc_n);
    end
    if (redir) exp_q.delete();
    i2_rvalid  = pend2;
    i2_rdata   = pend2_addr ^ 16'hA5A5;
    pend2      = o2_req;
    pend2_addr = o2_addr;
    if (o2_req) log2.push_back(o2_addr);
  endtask

  initial begin
    i_rst_n = 1'b0; i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
    i_redirect = 1'b0; i_redirect_pc = '0; i_instr_ready = 1'b0;
    i2_rvalid = 1'b0; i2_rdata = '0;
    gnt_en = 1'b1; auto_rsp = 1'b1; ready_v = 1'b1;
    pend = 0; pend_stale = 0; pend2 = 0; pend_addr = '0; pend2_addr = '0;
    repeat (2) @(negedge i_clk);

    // Reset state
    chk("rst_req", 32'(o_imem_req), 32'd0);
    chk("rst_addr", 32'(o_imem_addr), 32'h0000);
    chk("rst_valid", 32'(o_instr_valid), 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_instr", 32'(o_instr), 32'd0);
    chk("rst_instr_pc", 32'(o_instr_pc), 32'd0);
    chk("rst_hi_addr", 32'(o2_addr), 32'hFFFC);
    i_rst_n = 1'b1;
    cyc_n = 0;

    // Streaming with gnt high and rvalid one cycle after gnt
    repeat (16) cyc();
    chk("t1_first_req_cycle", 32'(grant_cyc[0]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("t1_addr", 32'(req_log[k]), 32'(2 * k));
      chk("t1_gap", 32'(grant_cyc[k+1] - grant_cyc[k]), 32'd2);
    end
    chk("t1_delivered", 32'(dlv_log.size()), 32'd7);

    // RESET_PC near the top of the address space wraps
    chk("t5_wrap0", 32'(log2[0]), 32'hFFFC);
    chk("t5_wrap1", 32'(log2[1]), 32'hFFFE);
    chk("t5_wrap2", 32'(log2[2]), 32'h0000);

    // Back-pressure: exactly DEPTH requests then stall
    gnt_en = 1'b0;
    repeat (8) cyc();
    chk("t2_drained", 32'(o_count), 32'd0);
    req_log.delete();
    gnt_en = 1'b1; ready_v = 1'b0;
    repeat (16) cyc();
    chk("t2_req_count", 32'(req_log.size()), 32'd4);
    chk("t2_req_low", 32'(o_imem_req), 32'd0);
    chk("t2_count", 32'(o_count), 32'd4);
    chk("t2_sb_depth", 32'(o_count), 32'(exp_q.size()));
    ready_v = 1'b1;
    cyc();
    ready_v = 1'b0;
    repeat (10) cyc();
    chk("t2_one_more_req", 32'(req_log.size()), 32'd5);
    chk("t2_count_after", 32'(o_count), 32'd4);
    chk("t2_req_low_after", 32'(o_imem_req), 32'd0);
    ready_v = 1'b1;
    repeat (12) cyc();

    // Redirect while a request is outstanding; late response dropped
    auto_rsp = 1'b0;
    for (int i = 0; i < 20 && !pend; i++) cyc();
    chk("t3_grant_seen", 32'(pend), 32'd1);
    cyc(1'b1, 16'h0101);
    cyc();
    chk("t3_flush_count", 32'(o_count), 32'd0);
    chk("t3_flush_valid", 32'(o_instr_valid), 32'd0);
    chk("t3_held_wait", 32'(o_imem_req), 32'd0);
    chk("t3_target_addr", 32'(o_imem_addr), 32'h0100);
    auto_rsp = 1'b1;
    req_log.delete(); dlv_log.delete();
    repeat (12) cyc();
    chk("t3_first_req", 32'(req_log[0]), 32'h0100);
    chk("t3_first_dlv", 32'(dlv_log[0]), 32'h0100);

    // Redirect in the same cycle as rvalid
    for (int i = 0; i < 20 && !pend; i++) cyc();
    chk("t4a_grant_seen", 32'(pend), 32'd1);
    req_log.delete(); grant_cyc.delete(); dlv_log.delete();
    cyc(1'b1, 16'h0200);
    c0 = cyc_n;
    repeat (12) cyc();
    chk("t4a_first_req", 32'(req_log[0]), 32'h0200);
    chk("t4a_req_next", 32'(grant_cyc[0]), 32'(c0 + 1));
    chk("t4a_first_dlv", 32'(dlv_log[0]), 32'h0200);

    // Redirect during REQ with gnt low: request withdrawn
    gnt_en = 1'b0;
    for (int i = 0; i < 20 && !o_imem_req; i++) cyc();
    chk("t4b_req_seen", 32'(o_imem_req), 32'd1);
    cyc(1'b1, 16'h0300);
    cyc();
    chk("t4b_withdrawn", 32'(o_imem_req), 32'd0);
    chk("t4b_count", 32'(o_count), 32'd0);
    gnt_en = 1'b1;
    req_log.delete(); dlv_log.delete();
    repeat (12) cyc();
    chk("t4b_first_req", 32'(req_log[0]), 32'h0300);
    chk("t4b_first_dlv", 32'(dlv_log[0]), 32'h0300);

    // Asynchronous reset mid-WAIT with three entries queued
    ready_v = 1'b0;
    for (int i = 0; i < 40 && !(pend && o_count == 3'd3); i++) cyc();
    chk("t6_setup", 32'(o_count), 32'd3);
    @(posedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(o_imem_req), 32'd0);
    chk("t6_rst_valid", 32'(o_instr_valid), 32'd0);
    chk("t6_rst_count", 32'(o_count), 32'd0);
    chk("t6_rst_addr", 32'(o_imem_addr), 32'h0000);
    chk("t6_rst_instr", 32'(o_instr), 32'd0);
    exp_q.delete();
    pend = 0; pend_stale = 0; pend2 = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    i_imem_rvalid = 1'b1; i_imem_rdata = 16'hDEAD; i_imem_gnt = 1'b0;
    i_redirect = 1'b0; i2_rvalid = 1'b0;
    @(negedge i_clk);
    i_imem_rvalid = 1'b0;
    chk("t6_stale_valid", 32'(o_instr_valid), 32'd0);
    chk("t6_stale_count", 32'(o_count), 32'd0);
    chk("t6_restart_req", 32'(o_imem_req), 32'd1);
    chk("t6_restart_addr", 32'(o_imem_addr), 32'h0000);
    ready_v = 1'b1;
    dlv_log.delete();
    repeat (10) cyc();
    chk("t6_first_dlv", 32'(dlv_log[0]), 32'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/z16_fetch_unit.md
Name: z16_fetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation Z16 core.
- Replaces the fixed "PC += 2 every cycle" sequencing with a handshaked instruction-memory port, a prefetch queue, branch/jump redirect with in-flight squash, and a valid/ready instruction output to decode.
- Sits between the instruction memory (or bus bridge) and the decoder stage.

Parameters:
- ADDR_W, 16, PC / fetch address width.
- INSTR_W, 16, instruction width; must be a multiple of 8. PC step is INSTR_W/8.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 0, PC loaded on reset.

Ports:
- i_clk, in, 1, clock; all state updates on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- o_imem_req, out, 1, fetch request valid.
- o_imem_addr, out, ADDR_W, fetch address; always aligned to INSTR_W/8.
- i_imem_gnt, in, 1, request accepted this cycle when high together with o_imem_req.
- i_imem_rvalid, in, 1, read data valid for the single outstanding request.
- i_imem_rdata, in, INSTR_W, read data.
- i_redirect, in, 1, one-cycle pulse: flush and restart fetch.
- i_redirect_pc, in, ADDR_W, target PC; low log2(INSTR_W/8) bits are forced to 0.
- o_instr_valid, out, 1, queue head valid.
- o_instr, out, INSTR_W, queue head instruction.
- o_instr_pc, out, ADDR_W, PC of the queue head.
- i_instr_ready, in, 1, decode consumes the head when high with o_instr_valid.
- o_count, out, $clog2(DEPTH)+1, current queue occupancy.

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc = RESET_PC; FSM = IDLE; queue empty; squash = 0.
  - All outputs 0 except o_imem_addr = RESET_PC.
- FSM states:
  - IDLE: o_imem_req = 0. Go to REQ when count + 0 outstanding < DEPTH and no redirect this cycle.
  - REQ: o_imem_req = 1, o_imem_addr = fetch_pc. Addr held stable until gnt. On gnt: fetch_pc += INSTR_W/8, go to WAIT.
  - WAIT: one request outstanding; o_imem_req = 0.
    - On rvalid, push {fetch address, rdata} unless squash is set; clear squash.
    - Same edge, go to REQ if there is space after the push/pop, else IDLE.
- Space rule: a request is issued only if occupancy plus outstanding is below DEPTH. The queue can never overflow, so rvalid never needs to be back-pressured.
- At most one outstanding request, ever.
- Latency:
  - First o_imem_req is high in the first cycle after reset release.
  - A pushed instruction appears on o_instr_valid the cycle after its rvalid (registered queue, no fall-through).
  - Best-case throughput is one instruction per 2 cycles (gnt and rvalid in consecutive cycles).
- Queue:
  - Circular buffer with ADDR_W+INSTR_W wide entries and wrapping read/write pointers.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pop when empty is ignored.
- Redirect (highest priority):
  - Queue is flushed (count = 0), fetch_pc = aligned i_redirect_pc, o_instr_valid = 0 next cycle.
  - If a request is outstanding (WAIT) and rvalid is not this cycle, squash is set and the later response is dropped. FSM stays in WAIT until that response.
  - Redirect while in REQ without gnt: the request is withdrawn. The memory must tolerate withdrawal.
  - Redirect in REQ with gnt the same cycle: treated as outstanding; squash is set.
  - Redirect and rvalid the same cycle: the data is dropped, squash is not set, and the next state is REQ.
  - A pop in the same cycle as a redirect is discarded.
- PC arithmetic is modulo 2^ADDR_W; 0xFFFE + 2 wraps to 0x0000 with no flag.
- Assertions:
  - o_imem_addr is stable while o_imem_req is high and gnt is low.
  - rvalid is never seen in IDLE or REQ.

Decomposition:
- Package z16_fetch_pkg:
  - FSM state enum {IDLE, REQ, WAIT}.
  - Derived constants: PC_STEP = INSTR_W/8; PTR_W = $clog2(DEPTH); ALIGN_BITS = $clog2(PC_STEP).
- Sub-module z16_fetch_queue: parametrised sync FIFO with flush, push, pop, count, head outputs.
- Top-level holds the FSM, PC and squash logic.

Test Plan:
- Reset, then gnt tied high and rvalid one cycle after each gnt with rdata = addr ^ 0xA5A5, i_instr_ready = 1 → addresses 0x0000, 0x0002, 0x0004…; o_instr/o_instr_pc pairs match in order; one instruction per 2 cycles.
- i_instr_ready = 0, DEPTH = 4 → exactly 4 requests issued, then o_imem_req stays 0 and o_count = 4. Raising ready for one cycle → one new request, with no overflow.
- Redirect to 0x0101 while in WAIT → queue empties; the late response is dropped; next o_imem_addr = 0x0100; first delivered instr_pc = 0x0100.
- Redirect the same cycle as rvalid, and redirect during REQ with gnt low → data dropped, request withdrawn, refetch from the new target with no stale instruction delivered.
- RESET_PC = 0xFFFC with 16-bit address → fetch sequence 0xFFFC, 0xFFFE, 0x0000.
- Assert i_rst_n low asynchronously mid-WAIT with the queue at 3 → outputs clear immediately; after release, fetch restarts at RESET_PC and the stale rvalid is ignored.
